boat_detector: RTL and testbench
================================

# boat_detector

Sensor front-end for the drawbridge controller: conditions two raw river sensors (far approach beam, near under-bridge beam) and produces the clean `i_boatClose` / `i_boatHere` levels the drawbridge consumes. Synchronizes and debounces both sensors, tracks each vessel through an approach/present/clearing state machine, counts completed passages, and flags approach timeouts and boats under a closed bridge. Sits directly upstream of the drawbridge; its `o_boatClose` and `o_boatHere` wire straight to the drawbridge's `i_boatClose` and `i_boatHere`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to accept a sensor change (≥1).
- `CLEAR_CYCLES`, default 8: cycles the near sensor must read clear before a boat counts as passed (≥1).
- `TIMEOUT_CYCLES`, default 64: maximum cycles in APPROACH without a near detection (≥2).
- `i_clk  in  1`: system clock, rising edge.
- `i_reset  in  1`: reset, asynchronous assert, active-low; deassertion is synchronous to `i_clk` upstream.
- `i_farSensor  in  1`: raw far-beam sensor, asynchronous, 1 = boat detected.
- `i_nearSensor  in  1`: raw near-beam sensor, asynchronous, 1 = boat detected.
- `i_bridgeOpen  in  1`: drawbridge fully open, synchronous.
- `o_boatClose  out  1`: boat approaching or at the bridge.
- `o_boatHere  out  1`: boat under or clearing the bridge.
- `o_collision  out  1`: boat present while bridge not open.
- `o_fault  out  1`: one-cycle pulse on approach timeout.
- `o_state  out  3`: current FSM state encoding.
- `o_boatCount  out  8`: completed passages, wraps modulo 256.

## Operation
- Each sensor passes through a 2-flop synchronizer, then a debouncer. The debounced value flips only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any matching sample resets the run counter.
- `far_rise` is a one-cycle pulse on a 0→1 transition of debounced far.
- States, with `o_state` encoding, outputs, and transitions:
  - IDLE = 0. `o_boatClose` = 0, `o_boatHere` = 0.
    - debounced near = 1 → PRESENT. Near has priority over far.
    - else `far_rise` → APPROACH.
  - APPROACH = 1. `o_boatClose` = 1, `o_boatHere` = 0.
    - debounced near = 1 → PRESENT.
    - else timer reaches `TIMEOUT_CYCLES` − 1 → IDLE and pulse `o_fault`.
  - PRESENT = 2. `o_boatClose` = 1, `o_boatHere` = 1.
    - debounced near = 0 → CLEARING, clear counter zeroed.
  - CLEARING = 3. `o_boatClose` = 1, `o_boatHere` = 1.
    - debounced near = 1 → PRESENT (boat re-detected; counter zeroed).
    - clear counter reaches `CLEAR_CYCLES` − 1 → increment `o_boatCount`.
      - next state APPROACH if debounced far = 1 (following boat);
      - otherwise IDLE.
- The timeout timer is zeroed on every entry to APPROACH and increments each cycle spent in APPROACH.
- `o_collision` = registered (state ∈ {PRESENT, CLEARING} and `i_bridgeOpen` = 0).
- `o_boatCount` wraps from 255 to 0 with no flag.
- All outputs are registered.
- Reset assertion, including mid-operation: immediately forces the following, with no pending count or fault completing.
  - state IDLE;
  - synchronizers, debouncers, timers cleared to 0;
  - `o_boatCount` = 0;
  - all outputs 0.

## Timing
- Reset values: `o_boatClose` = 0, `o_boatHere` = 0, `o_collision` = 0, `o_fault` = 0, `o_state` = 0, `o_boatCount` = 0.
- Raw edge to debounced change: 2 + `DEBOUNCE_CYCLES` rising edges.
- Raw edge to output change: 3 + `DEBOUNCE_CYCLES` edges (7 at default).
- Debounced near falling to `o_boatHere` = 0 (IDLE exit path): `CLEAR_CYCLES` + 1 edges. `o_boatCount` updates on the same edge.
- APPROACH entry to `o_fault` pulse: `TIMEOUT_CYCLES` edges. `o_state` = 0 on the same edge.
- `o_collision` follows `i_bridgeOpen` with 1-cycle latency.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles never reach the FSM.

## Configuration
- `BOAT_TIMEOUT_EN` defined: timeout timer and `o_fault` active as described.
- `BOAT_TIMEOUT_EN` undefined:
  - timer logic removed;
  - APPROACH waits indefinitely for near;
  - `o_fault` tied to 0.

## Test plan
- Reset → all outputs 0. Far held 1 from cycle 0 → `o_boatClose` = 1 at edge 7, `o_state` = 1.
- Full pass, defaults: far 1, near 1, near 0 → `o_boatHere` = 1 while near is high. `o_boatHere` drops and `o_boatCount` = 1 nine edges after debounced near falls; `o_state` returns to 0.
- Far glitch of 3 cycles → no state change. Near dropout of 5 cycles during CLEARING → returns to PRESENT, count unchanged.
- Far 1, near never asserted, `BOAT_TIMEOUT_EN` defined → `o_fault` = 1 for exactly one cycle, 64 edges after APPROACH entry; `o_state` = 0. Without the macro → stays in state 1.
- PRESENT with `i_bridgeOpen` = 0 → `o_collision` = 1 next edge; `i_bridgeOpen` 1 → 0 one edge later. Reset asserted mid-CLEARING → outputs 0 immediately, count 0.
- 256 passes → `o_boatCount` wraps to 0. Far held 1 at clearing end → next state APPROACH.

Source files
------------

// File: rtl/boat_detector.sv
// boat_detector: conditions the far/near river beams and tracks each vessel past the drawbridge.
// Optional approach timeout (timer + o_fault pulse) is built only when BOAT_TIMEOUT_EN is defined.

module boat_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] run_cnt;

  // Two-flop synchronizer, then accept a change only after an unbroken run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      run_cnt  <= '0;
      filtered <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == filtered) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= sync_2;
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

module boat_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLEAR_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_farSensor,
  input  logic       i_nearSensor,
  input  logic       i_bridgeOpen,
  output logic       o_boatClose,
  output logic       o_boatHere,
  output logic       o_collision,
  output logic       o_fault,
  output logic [2:0] o_state,
  output logic [7:0] o_boatCount
);

  if (DEBOUNCE_CYCLES < 1 || CLEAR_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("boat_detector: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPROACH = 3'd1,
    PRESENT  = 3'd2,
    CLEARING = 3'd3
  } state_t;

  localparam int CCW = $clog2(CLEAR_CYCLES + 1);

  state_t         state;
  logic           far_db;
  logic           near_db;
  logic           far_prev;
  logic           far_rise;
  logic [CCW-1:0] clear_cnt;

`ifdef BOAT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`else
  assign o_fault = 1'b0;
`endif

  boat_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_far_filter (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .raw      (i_farSensor),
    .filtered (far_db)
  );

  boat_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_near_filter (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .raw      (i_nearSensor),
    .filtered (near_db)
  );

  assign far_rise = far_db & ~far_prev;
  assign o_state  = state;

  // Vessel tracker: outputs are written alongside each transition so they stay registered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      far_prev    <= 1'b0;
      clear_cnt   <= '0;
      o_boatClose <= 1'b0;
      o_boatHere  <= 1'b0;
      o_collision <= 1'b0;
      o_boatCount <= '0;
`ifdef BOAT_TIMEOUT_EN
      timer       <= '0;
      o_fault     <= 1'b0;
`endif
    end else begin
      far_prev    <= far_db;
      o_collision <= ((state == PRESENT) || (state == CLEARING)) && !i_bridgeOpen;
`ifdef BOAT_TIMEOUT_EN
      o_fault     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (near_db) begin
            state       <= PRESENT;
            o_boatClose <= 1'b1;
            o_boatHere  <= 1'b1;
          end else if (far_rise) begin
            state       <= APPROACH;
            o_boatClose <= 1'b1;
`ifdef BOAT_TIMEOUT_EN
            timer       <= '0;
`endif
          end
        end
        APPROACH: begin
          if (near_db) begin
            state      <= PRESENT;
            o_boatHere <= 1'b1;
          end
`ifdef BOAT_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            o_boatClose <= 1'b0;
            o_fault     <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
`endif
        end
        PRESENT: begin
          if (!near_db) begin
            state     <= CLEARING;
            clear_cnt <= '0;
          end
        end
        CLEARING: begin
          if (near_db) begin
            state     <= PRESENT;
            clear_cnt <= '0;
          end else if (clear_cnt == CCW'(CLEAR_CYCLES - 1)) begin
            o_boatCount <= o_boatCount + 8'd1;
            o_boatHere  <= 1'b0;
            // A boat already on the far beam goes straight into its own approach.
            if (far_db) begin
              state <= APPROACH;
`ifdef BOAT_TIMEOUT_EN
              timer <= '0;
`endif
            end else begin
              state       <= IDLE;
              o_boatClose <= 1'b0;
            end
          end else begin
            clear_cnt <= clear_cnt + CCW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          o_boatClose <= 1'b0;
          o_boatHere  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boat_detector.sv
// Directed bench for boat_detector at default parameters; expected values travel through a scoreboard queue.
// Timeout checks follow whichever way BOAT_TIMEOUT_EN is set for the build.

module tb_boat_detector;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_farSensor = 1'b0;
  logic       i_nearSensor = 1'b0;
  logic       i_bridgeOpen = 1'b1;
  logic       o_boatClose;
  logic       o_boatHere;
  logic       o_collision;
  logic       o_fault;
  logic [2:0] o_state;
  logic [7:0] o_boatCount;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  boat_detector dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_farSensor  (i_farSensor),
    .i_nearSensor (i_nearSensor),
    .i_bridgeOpen (i_bridgeOpen),
    .o_boatClose  (o_boatClose),
    .o_boatHere   (o_boatHere),
    .o_collision  (o_collision),
    .o_fault      (o_fault),
    .o_state      (o_state),
    .o_boatCount  (o_boatCount)
  );

  always #5 i_clk = ~i_clk;

  task automatic applyStimulus(input logic far, input logic near, input logic bridge);
    i_farSensor  = far;
    i_nearSensor = near;
    i_bridgeOpen = bridge;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic expectValue(input string tag, input logic [7:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [7:0] observed);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    expectValue("rst_close", 8'd0);     checkOutput({7'd0, o_boatClose});
    expectValue("rst_here", 8'd0);      checkOutput({7'd0, o_boatHere});
    expectValue("rst_collision", 8'd0); checkOutput({7'd0, o_collision});
    expectValue("rst_fault", 8'd0);     checkOutput({7'd0, o_fault});
    expectValue("rst_state", 8'd0);     checkOutput({5'd0, o_state});
    expectValue("rst_count", 8'd0);     checkOutput(o_boatCount);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;

    // Far beam latency: boatClose on the 7th edge
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectValue("far_close_e6", 8'd0);
    expectValue("far_close_e7", 8'd1);
    expectValue("far_state_e7", 8'd1);
    tick(6); checkOutput({7'd0, o_boatClose});
    tick(1); checkOutput({7'd0, o_boatClose}); checkOutput({5'd0, o_state});

    // Near arrives: PRESENT
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectValue("near_here_e6", 8'd0);
    expectValue("near_here_e7", 8'd1);
    expectValue("near_state_e7", 8'd2);
    expectValue("open_no_collision", 8'd0);
    tick(6); checkOutput({7'd0, o_boatHere});
    tick(1); checkOutput({7'd0, o_boatHere}); checkOutput({5'd0, o_state});
    tick(1); checkOutput({7'd0, o_collision});

    // Near clears: debounced fall at edge 6, exit 9 edges later
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectValue("clr_state_e14", 8'd3);
    expectValue("clr_here_e14", 8'd1);
    expectValue("clr_count_e14", 8'd0);
    expectValue("pass_here_e15", 8'd0);
    expectValue("pass_count_e15", 8'd1);
    expectValue("pass_state_e15", 8'd0);
    expectValue("pass_close_e15", 8'd0);
    tick(14);
    checkOutput({5'd0, o_state}); checkOutput({7'd0, o_boatHere}); checkOutput(o_boatCount);
    tick(1);
    checkOutput({7'd0, o_boatHere}); checkOutput(o_boatCount);
    checkOutput({5'd0, o_state}); checkOutput({7'd0, o_boatClose});

    // Far glitch shorter than the debounce window
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectValue("glitch_state", 8'd0);
    expectValue("glitch_close", 8'd0);
    tick(12); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_boatClose});

    // Near with bridge closed: collision one edge after PRESENT, clears one edge after open
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectValue("coll_state_e7", 8'd2);
    expectValue("coll_e7", 8'd0);
    expectValue("coll_e8", 8'd1);
    expectValue("coll_clear", 8'd0);
    tick(7); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_collision});
    tick(1); checkOutput({7'd0, o_collision});
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1); checkOutput({7'd0, o_collision});

    // Near dropout of 5 cycles during CLEARING
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(5);
    applyStimulus(1'b0, 1'b1, 1'b1);
    expectValue("dropout_clearing", 8'd3);
    expectValue("dropout_present", 8'd2);
    expectValue("dropout_hold", 8'd2);
    expectValue("dropout_count", 8'd1);
    tick(5); checkOutput({5'd0, o_state});
    tick(2); checkOutput({5'd0, o_state});
    tick(4); checkOutput({5'd0, o_state}); checkOutput(o_boatCount);

    // Reset mid-CLEARING with bridge closed
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectValue("midrst_pre_state", 8'd3);
    expectValue("midrst_pre_coll", 8'd1);
    tick(9); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_collision});
    #1;
    i_reset = 1'b0;
    expectValue("midrst_close", 8'd0);
    expectValue("midrst_here", 8'd0);
    expectValue("midrst_state", 8'd0);
    expectValue("midrst_count", 8'd0);
    expectValue("midrst_coll", 8'd0);
    #1;
    checkOutput({7'd0, o_boatClose}); checkOutput({7'd0, o_boatHere});
    checkOutput({5'd0, o_state}); checkOutput(o_boatCount); checkOutput({7'd0, o_collision});
    #1;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectValue("postrst_count", 8'd0);
    expectValue("postrst_state", 8'd0);
    tick(12); checkOutput(o_boatCount); checkOutput({5'd0, o_state});

    // Approach with no near detection
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectValue("to_entry_state", 8'd1);
    tick(7); checkOutput({5'd0, o_state});
`ifdef BOAT_TIMEOUT_EN
    expectValue("to_e63_state", 8'd1);
    expectValue("to_e63_fault", 8'd0);
    expectValue("to_e64_fault", 8'd1);
    expectValue("to_e64_state", 8'd0);
    expectValue("to_e64_close", 8'd0);
    expectValue("to_e65_fault", 8'd0);
    tick(63); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_fault});
    tick(1);  checkOutput({7'd0, o_fault}); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_boatClose});
    tick(1);  checkOutput({7'd0, o_fault});
`else
    expectValue("noto_state", 8'd1);
    expectValue("noto_fault", 8'd0);
    tick(64); checkOutput({5'd0, o_state}); checkOutput({7'd0, o_fault});
`endif
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(2);
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    tick(10);

    // Near has priority over a simultaneous far rise; far held at clearing end starts a new approach
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectValue("prio_state", 8'd2);
    tick(7); checkOutput({5'd0, o_state});
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectValue("follow_pre_state", 8'd3);
    expectValue("follow_state", 8'd1);
    expectValue("follow_count", 8'd1);
    expectValue("follow_close", 8'd1);
    expectValue("follow_here", 8'd0);
    tick(14); checkOutput({5'd0, o_state});
    tick(1);
    checkOutput({5'd0, o_state}); checkOutput(o_boatCount);
    checkOutput({7'd0, o_boatClose}); checkOutput({7'd0, o_boatHere});
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectValue("follow_present", 8'd2);
    tick(7); checkOutput({5'd0, o_state});
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectValue("second_count", 8'd2);
    expectValue("second_state", 8'd0);
    tick(15); checkOutput(o_boatCount); checkOutput({5'd0, o_state});

    // Count wrap
    for (int p = 0; p < 253; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick(8);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(16);
    end
    expectValue("count_255", 8'd255);
    checkOutput(o_boatCount);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectValue("count_wrap", 8'd0);
    expectValue("wrap_state", 8'd0);
    tick(16); checkOutput(o_boatCount); checkOutput({5'd0, o_state});

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
